// File: rtl/genbuf_ctrl.sv
// genbuf_ctrl: handshake controller between two senders, a shared FIFO and two receivers.
// Latency: one cycle from a sampled request/status to the registered ack, strobe or offer.
// Backpressure: FULL=1 blocks new sender grants; EMPTY=1 blocks new receiver offers.
//
// Ports:
//   clock, reset          - single rising-edge clock, asynchronous active-high reset
//   StoB_REQ / BtoS_ACK   - four-phase request/ack with senders 0 and 1
//   BtoR_REQ / RtoB_ACK   - four-phase offer/accept with receivers 0 and 1
//   FULL, EMPTY           - registered FIFO status
//   ENQ, DEQ              - one-cycle FIFO write/read strobes
//   SLC                   - sender index muxed into the FIFO, valid while ENQ=1
//   PROTO_ERR             - sticky protocol-violation flag, cleared only by reset
//
// Build option: define GENBUF_SENDER_RR_EN for round-robin sender arbitration;
// without it, sender 0 has fixed priority.
module genbuf_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] StoB_REQ,
  output logic [1:0] BtoS_ACK,
  output logic [1:0] BtoR_REQ,
  input  logic [1:0] RtoB_ACK,
  input  logic       FULL,
  input  logic       EMPTY,
  output logic       ENQ,
  output logic       DEQ,
  output logic       SLC,
  output logic       PROTO_ERR
);

  typedef enum logic {S_IDLE, S_HOLD} s_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT_ACK, R_WAIT_REL} r_state_t;

  // Sender side state and registered outputs
  s_state_t   r_s_state, w_s_next;
  logic [1:0] r_ack, w_ack_next;
  logic       r_enq, w_enq_next;
  logic       r_slc, w_slc_next;
  logic       r_g, w_g_next;
  logic       w_sel;
  logic       w_s_err;
`ifdef GENBUF_SENDER_RR_EN
  logic       r_ls, w_ls_next;
`endif

  // Receiver side state and registered outputs
  r_state_t   r_r_state, w_r_next;
  logic [1:0] r_breq, w_breq_next;
  logic       r_deq, w_deq_next;
  logic       r_rp, w_rp_next;
  logic       w_nrp;

  logic       r_err, w_err_next;

  assign BtoS_ACK  = r_ack;
  assign ENQ       = r_enq;
  assign SLC       = r_slc;
  assign BtoR_REQ  = r_breq;
  assign DEQ       = r_deq;
  assign PROTO_ERR = r_err;

  // Sender arbitration: only consulted when at least one request is high.
`ifdef GENBUF_SENDER_RR_EN
  // Tie goes to the sender not served last; a lone requester wins directly.
  assign w_sel = (StoB_REQ == 2'b11) ? ~r_ls : StoB_REQ[1];
`else
  // Sender 0 wins whenever it requests.
  assign w_sel = ~StoB_REQ[0];
`endif

  // Sender FSM: next state and next registered outputs
  always_comb begin
    w_s_next   = r_s_state;
    w_ack_next = r_ack;
    w_enq_next = 1'b0;
    w_slc_next = r_slc;
    w_g_next   = r_g;
    w_s_err    = 1'b0;
`ifdef GENBUF_SENDER_RR_EN
    w_ls_next  = r_ls;
`endif
    case (r_s_state)
      S_IDLE: begin
        w_ack_next = 2'b00;
        if (!FULL && (|StoB_REQ)) begin
          w_ack_next = {w_sel, ~w_sel};
          w_enq_next = 1'b1;
          w_slc_next = w_sel;
          w_g_next   = w_sel;
`ifdef GENBUF_SENDER_RR_EN
          w_ls_next  = w_sel;
`endif
          w_s_next   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!StoB_REQ[r_g]) begin
          // A request withdrawn before its ack was seen is a sender violation.
          // The ack is raised on entry to S_HOLD, so this is a safety net only.
          w_s_err    = ~r_ack[r_g];
          w_ack_next = 2'b00;
          w_s_next   = S_IDLE;
        end
      end
      default: begin
        w_ack_next = 2'b00;
        w_s_next   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_s_state <= S_IDLE;
      r_ack     <= 2'b00;
      r_enq     <= 1'b0;
      r_slc     <= 1'b0;
      r_g       <= 1'b0;
`ifdef GENBUF_SENDER_RR_EN
      r_ls      <= 1'b1;
`endif
    end else begin
      r_s_state <= w_s_next;
      r_ack     <= w_ack_next;
      r_enq     <= w_enq_next;
      r_slc     <= w_slc_next;
      r_g       <= w_g_next;
`ifdef GENBUF_SENDER_RR_EN
      r_ls      <= w_ls_next;
`endif
    end
  end

  // Receiver FSM: strictly alternates between receivers via rp
  always_comb begin
    w_r_next    = r_r_state;
    w_breq_next = r_breq;
    w_deq_next  = 1'b0;
    w_rp_next   = r_rp;
    case (r_r_state)
      R_IDLE: begin
        w_breq_next = 2'b00;
        if (!EMPTY) begin
          // The word is popped up front and offered until accepted.
          w_deq_next  = 1'b1;
          w_breq_next = {r_rp, ~r_rp};
          w_r_next    = R_WAIT_ACK;
        end
      end
      R_WAIT_ACK: begin
        if (RtoB_ACK[r_rp]) begin
          w_breq_next = 2'b00;
          w_r_next    = R_WAIT_REL;
        end
      end
      R_WAIT_REL: begin
        if (!RtoB_ACK[r_rp]) begin
          w_rp_next = ~r_rp;
          w_r_next  = R_IDLE;
        end
      end
      default: begin
        w_breq_next = 2'b00;
        w_r_next    = R_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_r_state <= R_IDLE;
      r_breq    <= 2'b00;
      r_deq     <= 1'b0;
      r_rp      <= 1'b0;
    end else begin
      r_r_state <= w_r_next;
      r_breq    <= w_breq_next;
      r_deq     <= w_deq_next;
      r_rp      <= w_rp_next;
    end
  end

  // Sticky error: impossible FIFO status, an accept from the receiver not
  // being offered, or a premature sender release.
  assign w_nrp      = ~r_rp;
  assign w_err_next = r_err | (FULL & EMPTY) |
                      (RtoB_ACK[w_nrp] & ~r_breq[w_nrp]) | w_s_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_next;
    end
  end

endmodule

// File: tb/tb_genbuf_ctrl.sv
// tb_genbuf_ctrl: directed bench for genbuf_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Expected values are hand-derived; SLC tie order depends on GENBUF_SENDER_RR_EN.
module tb_genbuf_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] StoB_REQ = 2'b00;
  logic [1:0] RtoB_ACK = 2'b00;
  logic       FULL = 1'b0;
  logic       EMPTY = 1'b1;
  logic [1:0] BtoS_ACK;
  logic [1:0] BtoR_REQ;
  logic       ENQ;
  logic       DEQ;
  logic       SLC;
  logic       PROTO_ERR;

  logic [7:0] w_all;
  int n_checks = 0;
  int n_fail = 0;
  logic exp_slc [3];
  logic [1:0] exp_breq;

  genbuf_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .StoB_REQ (StoB_REQ),
    .BtoS_ACK (BtoS_ACK),
    .BtoR_REQ (BtoR_REQ),
    .RtoB_ACK (RtoB_ACK),
    .FULL     (FULL),
    .EMPTY    (EMPTY),
    .ENQ      (ENQ),
    .DEQ      (DEQ),
    .SLC      (SLC),
    .PROTO_ERR(PROTO_ERR)
  );

  assign w_all = {BtoS_ACK, BtoR_REQ, ENQ, DEQ, SLC, PROTO_ERR};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef GENBUF_SENDER_RR_EN
    exp_slc[0] = 1'b1; exp_slc[1] = 1'b0; exp_slc[2] = 1'b1;
`else
    exp_slc[0] = 1'b0; exp_slc[1] = 1'b0; exp_slc[2] = 1'b0;
`endif

    // Reset values, before any clock edge
    #2;
    check("reset_outs", w_all, 8'h00);
    step;
    step;
    reset = 1'b0;

    // Single sender 0 handshake
    StoB_REQ = 2'b01;
    step;
    check("t1_ack", BtoS_ACK, 2'b01);
    check("t1_enq", ENQ, 1'b1);
    check("t1_slc", SLC, 1'b0);
    check("t1_deq", DEQ, 1'b0);
    step;
    check("t1_enq_pulse", ENQ, 1'b0);
    check("t1_ack_hold", BtoS_ACK, 2'b01);
    StoB_REQ = 2'b00;
    step;
    check("t1_ack_drop", BtoS_ACK, 2'b00);

    // Both senders requesting over three transfers
    for (int k = 0; k < 3; k++) begin
      StoB_REQ = 2'b11;
      step;
      check("t2_enq", ENQ, 1'b1);
      check("t2_slc", SLC, exp_slc[k]);
      check("t2_ack", BtoS_ACK, exp_slc[k] ? 2'b10 : 2'b01);
      StoB_REQ = exp_slc[k] ? 2'b01 : 2'b10;
      step;
      check("t2_release", BtoS_ACK, 2'b00);
      check("t2_enq_low", ENQ, 1'b0);
    end
    StoB_REQ = 2'b00;

    // Receivers served alternately, each acking two cycles after the offer
    EMPTY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_breq = (k % 2 == 0) ? 2'b01 : 2'b10;
      step;
      check("t4_deq", DEQ, 1'b1);
      check("t4_breq", BtoR_REQ, exp_breq);
      step;
      check("t4_deq_pulse", DEQ, 1'b0);
      check("t4_breq_hold", BtoR_REQ, exp_breq);
      RtoB_ACK = exp_breq;
      step;
      check("t4_breq_drop", BtoR_REQ, 2'b00);
      RtoB_ACK = 2'b00;
      if (k == 2) EMPTY = 1'b1;
      step;
      check("t4_deq_rel", DEQ, 1'b0);
    end
    check("t4_perr", PROTO_ERR, 1'b0);

    // FULL blocks a grant; receiver 1 is next in line meanwhile
    FULL = 1'b1;
    EMPTY = 1'b0;
    StoB_REQ = 2'b01;
    for (int k = 0; k < 5; k++) begin
      step;
      check("t3_enq_full", ENQ, 1'b0);
      check("t3_ack_full", BtoS_ACK, 2'b00);
      if (k == 0) check("t3_breq", BtoR_REQ, 2'b10);
    end
    FULL = 1'b0;
    step;
    check("t3_ack", BtoS_ACK, 2'b01);
    check("t3_enq", ENQ, 1'b1);
    check("t3_slc", SLC, 1'b0);
    StoB_REQ = 2'b00;
    RtoB_ACK = 2'b10;
    step;
    check("t3_ack_drop", BtoS_ACK, 2'b00);
    check("t3_breq_drop", BtoR_REQ, 2'b00);
    RtoB_ACK = 2'b00;
    EMPTY = 1'b1;
    step;
    check("t3_perr", PROTO_ERR, 1'b0);

    // Simultaneous ENQ and DEQ, then a stray accept from receiver 1
    StoB_REQ = 2'b10;
    EMPTY = 1'b0;
    step;
    check("t5_enq", ENQ, 1'b1);
    check("t5_deq", DEQ, 1'b1);
    check("t5_ack", BtoS_ACK, 2'b10);
    check("t5_slc", SLC, 1'b1);
    check("t5_breq", BtoR_REQ, 2'b01);
    RtoB_ACK = 2'b10;
    step;
    check("t5_perr_set", PROTO_ERR, 1'b1);
    RtoB_ACK = 2'b00;
    EMPTY = 1'b1;
    StoB_REQ = 2'b00;
    step;
    step;
    check("t5_perr_sticky", PROTO_ERR, 1'b1);

    // Asynchronous reset mid-cycle clears everything, including PROTO_ERR
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_clr", w_all, 8'h00);
    step;
    reset = 1'b0;

    // Move rp to 1 with one receiver-0 handshake
    EMPTY = 1'b0;
    step;
    check("t6_breq0", BtoR_REQ, 2'b01);
    check("t6_deq0", DEQ, 1'b1);
    EMPTY = 1'b1;
    RtoB_ACK = 2'b01;
    step;
    check("t6_breq0_drop", BtoR_REQ, 2'b00);
    RtoB_ACK = 2'b00;
    step;

    // Sender 0 acked and receiver 1 offered, then reset mid-handshake
    EMPTY = 1'b0;
    StoB_REQ = 2'b01;
    step;
    check("t6_ack", BtoS_ACK, 2'b01);
    check("t6_breq1", BtoR_REQ, 2'b10);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_abort", w_all, 8'h00);
    step;
    check("t6_reset_edge", w_all, 8'h00);
    reset = 1'b0;
    StoB_REQ = 2'b00;
    step;
    check("t6_rp_zero", BtoR_REQ, 2'b01);
    check("t6_deq_after", DEQ, 1'b1);
    check("t6_perr", PROTO_ERR, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
